intersection_phase_ctrl: RTL and testbench
==========================================

# intersection_phase_ctrl

Green-phase scheduler for an N-approach intersection: per-approach vehicle sensors request service, and one approach at a time is granted green in round-robin order. Each granted phase runs green, then yellow, then an all-red clearance interval. Minimum/maximum green, yellow and clearance times are fixed by parameters. The block sits between the sensor modules and the light drivers and replaces the pairwise enable handshakes between per-road controllers with one central sequencer.

## Interface
- N, 4, number of approaches (2..8)
- MIN_GREEN, 8, minimum green cycles once granted
- MAX_GREEN, 32, maximum green cycles while another approach is requesting
- YELLOW_T, 3, yellow cycles
- ALLRED_T, 2, minimum all-red clearance cycles
- CW, 6, phase counter width; every time parameter must be below 2^CW
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- car_present  in  N  bit i = 1: vehicle waiting on approach i (already synchronous to clk)
- light  out  2*N  light[2i+1:2i] = color of approach i (GREEN=0, YELLOW=1, RED=2)
- active  out  clog2(N)  approach currently or most recently granted
- phase_start  out  1  one-cycle pulse in the first green cycle of each grant

## Operation
- Phase FSM states: ALLRED, GREEN, YELLOW. Phase counter `cnt` clears on every state entry.
- Reset values: state ALLRED, cnt 0, active N-1 (so the first scan starts at 0), all light fields RED, phase_start 0.
- ALLRED: cnt increments, saturating at ALLRED_T-1. When cnt == ALLRED_T-1 and car_present != 0, the FSM grants the first requesting approach in round-robin order active+1, active+2, …, active (mod N). It loads active and moves to GREEN. With no request it stays in ALLRED indefinitely.
- GREEN: cnt increments, saturating at MAX_GREEN-1. Exit to YELLOW when cnt >= MIN_GREEN-1, some other approach is requesting, and either car_present[active] == 0 or cnt == MAX_GREEN-1. With no competing request, green rests indefinitely, even if car_present[active] drops.
- YELLOW: exit to ALLRED when cnt == YELLOW_T-1. Requests are ignored.
- light: approach `active` is GREEN in GREEN and YELLOW in YELLOW. Every other field, and all fields in ALLRED, are RED. Encoding 3 is never driven.
- Safety invariant: at most one light field is non-RED in any cycle.
- A request that drops before the grant decision is not served. No request latching.

## Timing
- All outputs are registered or decoded directly from registers; there is no combinational path from car_present to any output.
- Grant decision edge → GREEN visible and phase_start = 1 in the next cycle.
- Green lasts at least MIN_GREEN cycles. Under competing demand it lasts at most MAX_GREEN cycles.
- Yellow lasts exactly YELLOW_T cycles. All-red lasts at least ALLRED_T cycles.
- After rst_n deasserts, at least ALLRED_T cycles pass before any green.
- Worst-case wait for a continuously requesting approach: (N-1)·(MAX_GREEN+YELLOW_T+ALLRED_T) cycles.
- Reset mid-phase: all lights RED immediately (asynchronously) and all registers return to reset values.

## Structure
- Shared package tlc_pkg holds the color enum (GREEN=0, YELLOW=1, RED=2) and the phase enum (ALLRED, GREEN, YELLOW). Existing light modules use the same color encoding.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: N-bit request vector and last index.
  - Outputs: next index and valid.
- The FSM, counter and output decode live in the top module.

## Test plan
All cases use default parameters.
- Reset, then car_present=4'b0100 held → 2 all-red cycles, then light[5:4]=GREEN, active=2, one phase_start pulse. Green persists for 100+ cycles with no other request.
- Approach 0 green with car_present=4'b0001. At green cnt 3, set car_present=4'b0010 → green totals 8 cycles, then 3 YELLOW, 2 ALLRED, then approach 1 GREEN.
- car_present=4'b1111 constant → grants in order 0,1,2,3,0. Each green is exactly 32 cycles and the grant period is 37 cycles.
- car_present drops to 0 during ALLRED → all RED held. Assert bit 3 for one cycle after clearance → approach 3 GREEN on the next edge.
- rst_n low mid-YELLOW → all fields RED in the same cycle, active=3, phase_start=0. Release → first green no sooner than 2 cycles later.
- 10k cycles of random car_present → assertion that at most one field is non-RED, and that min/max green and the yellow length hold every phase.

Source files
------------

// File: rtl/tlc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlc_pkg
// Description : Shared traffic-light types. The color encoding is common to
//               the phase sequencer and the downstream light driver modules.
//               Encoding 3 is reserved and never driven.
// Revision    : 1.0 - initial release
// ============================================================================
package tlc_pkg;

    // Width of one light field in the packed light vector
    localparam int c_color_w = 2;

    typedef enum logic [1:0] {
        CLR_GREEN  = 2'd0,
        CLR_YELLOW = 2'd1,
        CLR_RED    = 2'd2
    } color_t;

    typedef enum logic [1:0] {
        PH_ALLRED = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2
    } phase_t;

endpackage : tlc_pkg
`default_nettype wire

// File: rtl/intersection_phase_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : intersection_phase_ctrl_if
// Description : Bundle between the sensor modules, the phase sequencer and
//               the light drivers.
//   car_present [N]       : per-approach vehicle request (sync to clk)
//   light       [2N]      : light[2i+1:2i] = color of approach i
//   active      [clog2 N] : approach currently / most recently granted
//   phase_start [1]       : one-cycle pulse in the first green cycle
//   master : the sequencer (consumes requests, drives lights)
//   slave  : sensors / light drivers side
// Revision    : 1.0 - initial release
// ============================================================================
interface intersection_phase_ctrl_if
    import tlc_pkg::*;
#(
    parameter int N = 4
);
    localparam int c_aw = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]           car_present;
    logic [c_color_w*N-1:0] light;
    logic [c_aw-1:0]        active;
    logic                   phase_start;

    modport master (
        input  car_present,
        output light,
        output active,
        output phase_start
    );

    modport slave (
        output car_present,
        input  light,
        input  active,
        input  phase_start
    );

endinterface : intersection_phase_ctrl_if
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Scans last+1, last+2, ...,
//               last (mod N) and returns the first requesting index.
//   req   [N]  : request vector
//   last  [AW] : most recently granted index
//   next  [AW] : chosen index (equals last when nothing is requested)
//   valid [1]  : at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [AW-1:0] last,
    output logic [AW-1:0] next,
    output logic          valid
);

    int w_idx;

    // Walk from the farthest candidate (last itself) down to the nearest
    // (last+1) so the nearest requester is the final, winning assignment.
    always_comb begin
        next  = last;
        valid = 1'b0;
        w_idx = 0;
        for (int k = N; k >= 1; k--) begin
            w_idx = int'(last) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (req[w_idx]) begin
                next  = AW'(w_idx);
                valid = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/intersection_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : intersection_phase_ctrl
// Description : Central green-phase sequencer for an N-approach
//               intersection. One approach at a time runs
//               GREEN -> YELLOW -> ALL-RED, granted in round-robin order
//               among approaches with a waiting vehicle.
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset (all lights RED immediately)
//   bus   : master side of intersection_phase_ctrl_if
//           (car_present in; light, active, phase_start out)
// Revision    : 1.0 - initial release
// ============================================================================
module intersection_phase_ctrl
    import tlc_pkg::*;
#(
    parameter int N         = 4,
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 32,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int CW        = 6
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    intersection_phase_ctrl_if.master bus
);

    localparam int c_aw = (N > 1) ? $clog2(N) : 1;

    // Terminal counts, pre-sized to the counter width
    localparam logic [CW-1:0] c_allred_last = CW'(ALLRED_T - 1);
    localparam logic [CW-1:0] c_min_last    = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0] c_max_last    = CW'(MAX_GREEN - 1);
    localparam logic [CW-1:0] c_yel_last    = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] c_cnt_one     = CW'(1);

    localparam logic [c_color_w*N-1:0] c_all_red = {N{CLR_RED}};

    phase_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [c_aw-1:0]        r_active;
    logic [c_color_w*N-1:0] r_light;
    logic                   r_phase_start;

    logic [c_aw-1:0]        w_pick;
    logic                   w_pick_valid;
    logic [N-1:0]           w_active_mask;
    logic                   w_others;
    logic                   w_own;

    // Light vector with one approach at color c and all others RED
    function automatic logic [c_color_w*N-1:0] f_decode(
        input logic [c_aw-1:0] idx,
        input color_t          c
    );
        logic [c_color_w*N-1:0] v;
        v = c_all_red;
        for (int i = 0; i < N; i++) begin
            if (i == int'(idx)) begin
                v[c_color_w*i +: c_color_w] = c;
            end
        end
        return v;
    endfunction

    rr_pick #(
        .N  (N),
        .AW (c_aw)
    ) u_rr_pick (
        .req   (bus.car_present),
        .last  (r_active),
        .next  (w_pick),
        .valid (w_pick_valid)
    );

    // Competing demand = any requester other than the current holder
    assign w_active_mask = N'(1) << r_active;
    assign w_others      = |(bus.car_present & ~w_active_mask);
    assign w_own         = bus.car_present[r_active];

    // Phase FSM. Light and phase_start are loaded on the same edge as the
    // state transition so every output is a flop with async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= PH_ALLRED;
            r_cnt         <= '0;
            r_active      <= c_aw'(N - 1);
            r_light       <= c_all_red;
            r_phase_start <= 1'b0;
        end else begin
            r_phase_start <= 1'b0;
            unique case (r_state)
                PH_ALLRED: begin
                    if (r_cnt == c_allred_last && w_pick_valid) begin
                        r_state       <= PH_GREEN;
                        r_cnt         <= '0;
                        r_active      <= w_pick;
                        r_light       <= f_decode(w_pick, CLR_GREEN);
                        r_phase_start <= 1'b1;
                    end else if (r_cnt != c_allred_last) begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                PH_GREEN: begin
                    // Green rests indefinitely unless someone else waits
                    if (r_cnt >= c_min_last && w_others &&
                        (!w_own || r_cnt == c_max_last)) begin
                        r_state <= PH_YELLOW;
                        r_cnt   <= '0;
                        r_light <= f_decode(r_active, CLR_YELLOW);
                    end else if (r_cnt != c_max_last) begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                PH_YELLOW: begin
                    if (r_cnt == c_yel_last) begin
                        r_state <= PH_ALLRED;
                        r_cnt   <= '0;
                        r_light <= c_all_red;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= PH_ALLRED;
                    r_cnt   <= '0;
                    r_light <= c_all_red;
                end
            endcase
        end
    end

    assign bus.light       = r_light;
    assign bus.active      = r_active;
    assign bus.phase_start = r_phase_start;

endmodule : intersection_phase_ctrl
`default_nettype wire

// File: tb/tb_intersection_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_intersection_phase_ctrl
// Description : Self-checking bench for intersection_phase_ctrl. A
//               dwell-time model of the intersection predicts every output
//               each cycle; a run-length monitor checks phase durations and
//               the single-non-red invariant; directed scenarios pin literal
//               values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intersection_phase_ctrl;

    localparam int N         = 4;
    localparam int MIN_GREEN = 8;
    localparam int MAX_GREEN = 32;
    localparam int YELLOW_T  = 3;
    localparam int ALLRED_T  = 2;
    localparam int CW        = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    intersection_phase_ctrl_if #(.N(N)) ifc ();

    intersection_phase_ctrl #(
        .N         (N),
        .MIN_GREEN (MIN_GREEN),
        .MAX_GREEN (MAX_GREEN),
        .YELLOW_T  (YELLOW_T),
        .ALLRED_T  (ALLRED_T),
        .CW        (CW)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Dwell-time model: phase 0=all-red, 1=green, 2=yellow; dwell counts
    // completed cycles in the current phase without saturation.
    // ------------------------------------------------------------------
    int          m_phase  = 0;
    int          m_dwell  = 0;
    int          m_active = N - 1;
    bit          m_ps     = 1'b0;
    bit          m_valid  = 1'b0;
    logic [N-1:0] m_cp;

    function automatic logic [31:0] model_light();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (i == m_active && m_phase == 1)      v[2*i +: 2] = 2'd0;
            else if (i == m_active && m_phase == 2) v[2*i +: 2] = 2'd1;
            else                                    v[2*i +: 2] = 2'd2;
        end
        return v;
    endfunction

    always @(posedge clk) begin
        m_cp = ifc.car_present;
        if (!rst_n) begin
            m_phase = 0; m_dwell = 0; m_active = N - 1; m_ps = 1'b0;
        end else begin
            m_ps = 1'b0;
            if (m_phase == 0) begin
                if (m_dwell + 1 >= ALLRED_T && m_cp != '0) begin
                    bit found;
                    found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        if (!found && m_cp[(m_active + k) % N]) begin
                            m_active = (m_active + k) % N;
                            found = 1'b1;
                        end
                    end
                    m_phase = 1; m_dwell = 0; m_ps = 1'b1;
                end else begin
                    m_dwell++;
                end
            end else if (m_phase == 1) begin
                bit others;
                others = 1'b0;
                for (int j = 0; j < N; j++)
                    if (j != m_active && m_cp[j]) others = 1'b1;
                if (m_dwell + 1 >= MIN_GREEN && others &&
                    (!m_cp[m_active] || m_dwell + 1 >= MAX_GREEN)) begin
                    m_phase = 2; m_dwell = 0;
                end else begin
                    m_dwell++;
                end
            end else begin
                if (m_dwell + 1 >= YELLOW_T) begin
                    m_phase = 0; m_dwell = 0;
                end else begin
                    m_dwell++;
                end
            end
        end
        m_valid = 1'b1;
    end

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            check("model_light", 32'(ifc.light), model_light());
            check("model_active", 32'(ifc.active), 32'(m_active));
            check("model_phase_start", 32'(ifc.phase_start), 32'(m_ps));
        end
    end

    // ------------------------------------------------------------------
    // Run-length monitor on observed lights. car_present seen here is the
    // value the previous cycle's closing edge acted on.
    // ------------------------------------------------------------------
    int prev_cur = 0;
    int prev_act = 0;
    int g_len    = 0;
    int y_len    = 0;
    bit comp     = 1'b1;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            prev_cur = 0; g_len = 0; y_len = 0; comp = 1'b1;
        end else begin
            int cur, nonred, act_i;
            if (prev_cur == 1 && comp)
                comp = |(ifc.car_present & ~(4'b0001 << prev_act));
            cur = 0; nonred = 0; act_i = 0;
            for (int i = 0; i < N; i++) begin
                if (ifc.light[2*i +: 2] != 2'd2) begin
                    nonred++;
                    act_i = i;
                    cur = (ifc.light[2*i +: 2] == 2'd0) ? 1 : 2;
                end
            end
            check("single_nonred", 32'(nonred <= 1), 32'd1);
            if (prev_cur == 1 && cur != 1) begin
                check("green_min", 32'(g_len >= MIN_GREEN), 32'd1);
                if (comp) check("green_max", 32'(g_len <= MAX_GREEN), 32'd1);
            end
            if (prev_cur == 2 && cur != 2)
                check("yellow_len", 32'(y_len), 32'(YELLOW_T));
            if (cur == 1) begin
                if (prev_cur != 1) begin g_len = 1; comp = 1'b1; end
                else g_len++;
            end
            if (cur == 2) y_len = (prev_cur == 2) ? y_len + 1 : 1;
            prev_cur = cur;
            prev_act = act_i;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus (driven on the falling edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [N-1:0] cp);
        @(negedge clk);
        rst_n = 1'b0;
        ifc.car_present = cp;
        tick(2);
        rst_n = 1'b1;
    endtask

    int ticks;
    int g_act [5];
    int g_tim [5];
    int n_g;

    initial begin
        ifc.car_present = '0;

        // Reset values and first grant after all-red clearance
        do_reset(4'b0100);
        check("rst_light", 32'(ifc.light), 32'h0000_00AA);
        check("rst_active", 32'(ifc.active), 32'd3);
        check("rst_ps", 32'(ifc.phase_start), 32'd0);
        ticks = 0;
        while (ifc.light[5:4] != 2'd0 && ticks < 20) begin tick(1); ticks++; end
        check("first_green_delay", 32'(ticks), 32'd2);
        check("a_light", 32'(ifc.light), 32'h0000_008A);
        check("a_active", 32'(ifc.active), 32'd2);
        check("a_ps_pulse", 32'(ifc.phase_start), 32'd1);
        tick(1);
        check("a_ps_drop", 32'(ifc.phase_start), 32'd0);
        tick(100);
        check("a_green_rest", 32'(ifc.light), 32'h0000_008A);

        // Min-green exit, yellow, clearance, next approach
        do_reset(4'b0001);
        tick(2);
        check("b_green0", 32'(ifc.light), 32'h0000_00A8);
        tick(3);
        ifc.car_present = 4'b0010;
        tick(4);
        check("b_green_last", 32'(ifc.light), 32'h0000_00A8);
        tick(1);
        check("b_yellow", 32'(ifc.light), 32'h0000_00A9);
        tick(2);
        check("b_yellow_last", 32'(ifc.light), 32'h0000_00A9);
        tick(1);
        check("b_allred", 32'(ifc.light), 32'h0000_00AA);
        tick(1);
        check("b_allred2", 32'(ifc.light), 32'h0000_00AA);
        tick(1);
        check("b_green1", 32'(ifc.light), 32'h0000_00A2);
        check("b_active1", 32'(ifc.active), 32'd1);

        // Full demand: round-robin order and 37-cycle grant period
        do_reset(4'b1111);
        n_g = 0;
        for (int t = 1; t <= 200 && n_g < 5; t++) begin
            tick(1);
            if (ifc.phase_start) begin
                g_act[n_g] = int'(ifc.active);
                g_tim[n_g] = t;
                n_g++;
            end
        end
        check("c_grants", 32'(n_g), 32'd5);
        for (int i = 0; i < n_g; i++) begin
            check("c_order", 32'(g_act[i]), 32'(i % N));
            if (i > 0) check("c_period", 32'(g_tim[i] - g_tim[i-1]), 32'd37);
        end

        // Request dropped during all-red is not served; one-cycle request
        do_reset(4'b0100);
        ifc.car_present = '0;
        tick(10);
        check("d_hold_red", 32'(ifc.light), 32'h0000_00AA);
        ifc.car_present = 4'b1000;
        tick(1);
        check("d_green3", 32'(ifc.light), 32'h0000_002A);
        check("d_active3", 32'(ifc.active), 32'd3);
        ifc.car_present = '0;
        tick(5);
        check("d_green_rest", 32'(ifc.light), 32'h0000_002A);

        // Asynchronous reset in the middle of yellow
        ifc.car_present = 4'b0001;
        ticks = 0;
        while (ifc.light[7:6] != 2'd1 && ticks < 40) begin tick(1); ticks++; end
        check("e_reach_yellow", 32'(ifc.light[7:6]), 32'd1);
        tick(1);
        rst_n = 1'b0;
        #1;
        check("e_async_light", 32'(ifc.light), 32'h0000_00AA);
        check("e_async_active", 32'(ifc.active), 32'd3);
        check("e_async_ps", 32'(ifc.phase_start), 32'd0);
        tick(2);
        rst_n = 1'b1;
        ticks = 0;
        while (ifc.light[1:0] != 2'd0 && ticks < 20) begin tick(1); ticks++; end
        check("e_green_delay", 32'(ticks), 32'd2);
        check("e_active0", 32'(ifc.active), 32'd0);

        // Randomized demand with one mid-run reset
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (i == 5000) rst_n = 1'b0;
            if (i == 5003) rst_n = 1'b1;
            if ($urandom_range(0, 7) == 0)
                ifc.car_present = N'($urandom_range(0, 15));
        end

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_intersection_phase_ctrl
`default_nettype wire
